acc_pipe_mul: RTL and testbench
===============================

// Module: acc_pipe_mul
// PURPOSE
//  Parametrised, pipelined successor of the 8x8 four-quadrant approximate multiplier.
//  - Splits each WIDTH-bit unsigned operand into high/low halves.
//  - Forms four sub-products HH, HL, LH and LL, each approximated by its own runtime 2-bit mode.
//  - Shift-adds the sub-products into a 2*WIDTH-bit product.
//  - 3-stage pipeline with valid/ready handshake; sits between operand source and accumulator datapath.
// PARAMETERS
//  WIDTH    8  operand width; even, >=4; half width H=WIDTH/2
//  TRUNC_LO 1  low bits zeroed in a sub-product for mode 01; 0 < TRUNC_LO < TRUNC_HI
//  TRUNC_HI 2  low bits zeroed in a sub-product for mode 10; TRUNC_HI < 2*H
//  MODE_RST 8'h16  reset value of the mode register (HH=00, HL=01, LH=01, LL=10)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block can accept
//  a          in   WIDTH    unsigned multiplicand
//  b          in   WIDTH    unsigned multiplier
//  cfg_mode   in   8        [7:6]=HH [5:4]=HL [3:2]=LH [1:0]=LL; sampled with operands
//  out_valid  out  1        product valid
//  out_ready  in   1        downstream accepts
//  prod       out  2*WIDTH  approximate product
// BEHAVIOUR
//  - Reset: all stage valids=0, out_valid=0, prod=0, stage data=0, internal mode regs=MODE_RST.
//  - Accept when in_valid&&in_ready. Pipeline enable en = !out_valid || out_ready; in_ready=en.
//  - When en=0 every stage holds (full stall); no data is lost or duplicated.
//  - Bubbles propagate as valid=0; stage data may be left stale under a bubble.
//  - S1: register a, b and cfg_mode on accept.
//  - S2: compute and register ah*bh, ah*bl, al*bh, al*bl, each 2H bits.
//    Mode 00 exact; 01 clears [TRUNC_LO-1:0]; 10 clears [TRUNC_HI-1:0]; 11 forces the sub-product to 0.
//  - S3: prod = HH<<WIDTH + (HL+LH)<<H + LL; full 2*WIDTH result, no overflow possible.
//  - Latency: accept at cycle N -> out_valid at N+3 when no stall; throughput 1/cycle.
//  - prod/out_valid hold stable while out_valid && !out_ready.
//  - Mode change between operand pairs applies only to pairs accepted afterwards; in-flight pairs keep their sampled mode.
//  - Simultaneous out handshake and in accept in the same cycle: both complete, pipeline shifts by one.
//  - Reset mid-operation: all in-flight results discarded, outputs return to reset values immediately.
// CONFIGURATION
//  - Macro ACC_ERR_STATS_EN compiled in:
//    - Exact product a*b is carried alongside the pipeline.
//    - Extra ports: stat_clr in 1; err_cnt out 32; err_max out 2*WIDTH.
//    - On each out handshake where prod!=exact: err_cnt +1, saturating at 32'hFFFF_FFFF.
//    - err_max = max(err_max, exact-prod).
//    - stat_clr=1 clears both next cycle and takes priority over a same-cycle update.
//    - Both reset to 0.
//  - Macro absent: no exact path, no stats ports, identical datapath timing.
// TESTING (WIDTH=8, defaults)
//  1 cfg 8'h00, a=FF b=FF -> prod=16'hFE01 three cycles after accept.
//  2 cfg 8'h16, a=FF b=FF -> prod=16'hFDE0; with ACC_ERR_STATS_EN: err_cnt=1, err_max=33.
//  3 cfg 8'h03, a=0F b=0F -> prod=0; cfg 8'h00 next beat, same operands -> prod=16'h00E1, in order.
//  4 stream 8 random pairs, out_ready low 4 cycles mid-stream:
//    in_ready drops, prod held stable, all 8 results arrive in order and match the model.
//  5 rst_n low with 3 pairs in flight -> out_valid=0 and prod=0 at once; after release first new result has latency 3.
//  6 back-to-back accept with out_ready=1 and cfg changed every beat -> each result uses its own sampled mode.

Source files
------------

// File: rtl/acc_pipe_mul.sv
// -----------------------------------------------------------------------------
// acc_pipe_mul
//   Pipelined four-quadrant approximate multiplier. Each WIDTH-bit unsigned
//   operand is split into high/low halves. The four sub-products HH, HL, LH
//   and LL are each approximated under their own 2-bit mode:
//     00 exact, 01 clear TRUNC_LO low bits, 10 clear TRUNC_HI low bits,
//     11 force to zero.
//   The sub-products are then shift-added into a 2*WIDTH-bit product.
//   Three register stages (operands -> sub-products -> product) sit behind a
//   valid/ready handshake. The whole pipeline stalls as one unit whenever the
//   output holds an unaccepted result.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; a, b, cfg_mode sampled on accept
//   a, b                 WIDTH-bit unsigned operands
//   cfg_mode             [7:6]=HH [5:4]=HL [3:2]=LH [1:0]=LL approximation modes
//   out_valid/out_ready  result handshake
//   prod                 2*WIDTH-bit approximate product
//
// Optional feature (macro ACC_ERR_STATS_EN)
//   Carries the exact product down the pipeline and keeps error statistics:
//   stat_clr (in), err_cnt (out, 32-bit saturating count of inexact results),
//   err_max (out, largest exact-prod seen). Datapath timing is unchanged.
// -----------------------------------------------------------------------------
module acc_pipe_mul #(
  parameter int         WIDTH    = 8,
  parameter int         TRUNC_LO = 1,
  parameter int         TRUNC_HI = 2,
  parameter logic [7:0] MODE_RST = 8'h16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [7:0]           cfg_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
`ifdef ACC_ERR_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          err_cnt,
  output logic [2*WIDTH-1:0]   err_max
`endif
);

  localparam int H = WIDTH / 2;

  typedef logic [WIDTH-1:0]   sub_t;   // one sub-product, 2H bits
  typedef logic [2*WIDTH-1:0] full_t;  // full product

  localparam sub_t MASK_LO = {WIDTH{1'b1}} << TRUNC_LO;
  localparam sub_t MASK_HI = {WIDTH{1'b1}} << TRUNC_HI;

  function automatic sub_t approx(input sub_t p, input logic [1:0] m);
    case (m)
      2'b00:   return p;
      2'b01:   return p & MASK_LO;
      2'b10:   return p & MASK_HI;
      default: return '0;
    endcase
  endfunction

  // Single enable for all stages: move only when the output slot is free or
  // being drained this cycle, so nothing is dropped or duplicated.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: sampled operands and mode
  logic       s1_v;
  sub_t       s1_a, s1_b;
  logic [7:0] s1_mode;

  // Stage 2: approximated sub-products
  logic s2_v;
  sub_t s2_hh, s2_hl, s2_lh, s2_ll;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours and the stages
  // shift together instead of racing through in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= MODE_RST;
    end else if (en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_mode <= cfg_mode;
      end
    end
  end

  // Sub-products are computed at full 2H width; the halves are zero-extended
  // so the multiply is sized by its operands, not by truncation afterwards.
  sub_t pp_hh, pp_hl, pp_lh, pp_ll;
  sub_t ah_x, al_x, bh_x, bl_x;

  // NOTE: every always_comb output gets a value on every path (here by
  // straight-line assignment, elsewhere via defaults) so no latch is inferred.
  always_comb begin
    ah_x  = {{H{1'b0}}, s1_a[WIDTH-1:H]};
    al_x  = {{H{1'b0}}, s1_a[H-1:0]};
    bh_x  = {{H{1'b0}}, s1_b[WIDTH-1:H]};
    bl_x  = {{H{1'b0}}, s1_b[H-1:0]};
    pp_hh = approx(ah_x * bh_x, s1_mode[7:6]);
    pp_hl = approx(ah_x * bl_x, s1_mode[5:4]);
    pp_lh = approx(al_x * bh_x, s1_mode[3:2]);
    pp_ll = approx(al_x * bl_x, s1_mode[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_hh <= '0;
      s2_hl <= '0;
      s2_lh <= '0;
      s2_ll <= '0;
    end else if (en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_hh <= pp_hh;
        s2_hl <= pp_hl;
        s2_lh <= pp_lh;
        s2_ll <= pp_ll;
      end
    end
  end

  // Stage 3: HH<<WIDTH + LL is a plain concatenation; the middle pair needs
  // one carry bit before being shifted into place by H.
  logic [WIDTH:0] mid_sum;
  full_t          prod_c;

  always_comb begin
    mid_sum = {1'b0, s2_hl} + {1'b0, s2_lh};
    prod_c  = {s2_hh, s2_ll} + ({{(WIDTH-1){1'b0}}, mid_sum} << H);
  end

  // prod only loads real results, so it holds its last value under bubbles
  // and stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
    end else if (en) begin
      out_valid <= s2_v;
      if (s2_v) prod <= prod_c;
    end
  end

`ifdef ACC_ERR_STATS_EN
  // Exact reference travelling in lock-step with the approximate datapath.
  full_t s2_exact, s3_exact, err_diff;

  assign err_diff = s3_exact - prod;  // approximation never exceeds exact

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_exact <= '0;
      s3_exact <= '0;
    end else if (en) begin
      if (s1_v) s2_exact <= {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
      if (s2_v) s3_exact <= s2_exact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (stat_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (out_valid && out_ready && (prod != s3_exact)) begin
      if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
      if (err_diff > err_max)       err_max <= err_diff;
    end
  end
`endif

endmodule

// File: tb/tb_acc_pipe_mul.sv
// -----------------------------------------------------------------------------
// tb_acc_pipe_mul
//   Directed bench for acc_pipe_mul at WIDTH=8 with default parameters.
//   Expected products come from hand-computed constants or from an
//   independent arithmetic model of the approximation rules.
// -----------------------------------------------------------------------------
module tb_acc_pipe_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [7:0]  cfg_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] prod;
`ifdef ACC_ERR_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] err_cnt;
  logic [15:0] err_max;
`endif

  acc_pipe_mul #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cfg_mode  (cfg_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
`ifdef ACC_ERR_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .err_cnt   (err_cnt),
    .err_max   (err_max)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int got   = 0;
  logic [15:0] expq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int apply_mode(input int p, input logic [1:0] m);
    case (m)
      2'd0:    return p;
      2'd1:    return p - (p % 2);
      2'd2:    return p - (p % 4);
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] c);
    int xh, xl, yh, yl, hh, hl, lh, ll;
    xh = int'(x[7:4]);  xl = int'(x[3:0]);
    yh = int'(y[7:4]);  yl = int'(y[3:0]);
    hh = apply_mode(xh * yh, c[7:6]);
    hl = apply_mode(xh * yl, c[5:4]);
    lh = apply_mode(xl * yh, c[3:2]);
    ll = apply_mode(xl * yl, c[1:0]);
    return 16'(hh * 256 + (hl + lh) * 16 + ll);
  endfunction

  // One clock of stimulus: drive inputs, check any presented result against
  // the expected-queue head, record an accepted pair, then advance one edge.
  task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] cv, input logic ordy, input logic [15:0] ev,
                      output logic acc, output logic ir);
    in_valid  = iv;
    a         = av;
    b         = bv;
    cfg_mode  = cv;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    acc = iv && in_ready;
    if (out_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        check("stream_prod", prod, expq[0]);
        if (ordy) begin
          void'(expq.pop_front());
          got++;
        end
      end
    end
    if (acc) expq.push_back(ev);
    @(posedge clk); #1;
  endtask

  // Single isolated transaction: counts edges from the accept edge (inclusive)
  // until out_valid, then checks the product and lets it drain.
  task automatic run_one(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] cv, input logic [15:0] ev);
    int n;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    cfg_mode  = cv;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_prod"}, prod, ev);
    @(posedge clk); #1;
  endtask

  logic [7:0] ra[8], rb[8], rc[8];
  logic       acc, ir;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idx, n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_prod", prod, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: exact mode
    run_one("t1_exact", 8'hFF, 8'hFF, 8'h00, 16'hFE01);

    // 2: reset-default mode mix
    run_one("t2_default", 8'hFF, 8'hFF, 8'h16, 16'hFDE0);
`ifdef ACC_ERR_STATS_EN
    check("t2_err_cnt", err_cnt, 32'd1);
    check("t2_err_max", err_max, 32'd33);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr_cnt", err_cnt, 32'd0);
    check("stat_clr_max", err_max, 32'd0);
`endif

    // 3: LL forced to zero, then exact on the next beat, in order
    in_valid = 1'b1; a = 8'h0F; b = 8'h0F; cfg_mode = 8'h03;
    @(posedge clk); #1;
    cfg_mode = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t3_v0", {31'd0, out_valid}, 32'd1);
    check("t3_p0", prod, 32'h0000);
    @(posedge clk); #1;
    check("t3_v1", {31'd0, out_valid}, 32'd1);
    check("t3_p1", prod, 32'h00E1);
    @(posedge clk); #1;
    check("t3_idle", {31'd0, out_valid}, 32'd0);

    // 4: random stream with a 4-cycle downstream stall mid-stream
    for (int i = 0; i < 8; i++) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
      rc[i] = 8'($urandom);
    end
    expq.delete();
    got = 0;
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      logic ordy;
      ordy = !(i >= 5 && i < 9);
      if (idx < 8)
        step(1'b1, ra[idx], rb[idx], rc[idx], ordy, model(ra[idx], rb[idx], rc[idx]), acc, ir);
      else
        step(1'b0, 8'h00, 8'h00, 8'h00, ordy, 16'h0000, acc, ir);
      if (acc) idx++;
      if (!ordy) check("t4_stall_in_ready", {31'd0, ir}, 32'd0);
    end
    n = 0;
    while (got < 8 && n < 30) begin
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 16'h0000, acc, ir);
      n++;
    end
    check("t4_accepted", idx, 8);
    check("t4_results", got, 8);
    check("t4_queue_empty", expq.size(), 0);

    // 5: reset with three pairs in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'h11 + 8'(i), 8'h22, 8'h00, 1'b1, model(8'h11 + 8'(i), 8'h22, 8'h00), acc, ir);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_prod", prod, 32'd0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("t5_after_rst", 8'h12, 8'h34, 8'h00, 16'h03A8);

    // 6: back-to-back beats, mode changes every beat
    got = 0;
    step(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, 16'hFE01, acc, ir);
    check("t6_b2b_ready0", {31'd0, ir}, 32'd1);
    step(1'b1, 8'hFF, 8'hFF, 8'h16, 1'b1, 16'hFDE0, acc, ir);
    check("t6_b2b_ready1", {31'd0, ir}, 32'd1);
    step(1'b1, 8'hFF, 8'hFF, 8'hC0, 1'b1, 16'h1D01, acc, ir);
    check("t6_b2b_ready2", {31'd0, ir}, 32'd1);
    step(1'b1, 8'hFF, 8'hFF, 8'h3C, 1'b1, 16'hE1E1, acc, ir);
    check("t6_b2b_ready3", {31'd0, ir}, 32'd1);
    step(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 16'h0000, acc, ir);
    check("t6_b2b_ready4", {31'd0, ir}, 32'd1);
    n = 0;
    while (got < 5 && n < 20) begin
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 16'h0000, acc, ir);
      n++;
    end
    check("t6_results", got, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
